// File: rtl/ws2812b_chain.sv
// ws2812b_chain: streams NUM_PIXELS 24-bit {g,r,b} pixels onto a WS2812B serial
// line. It takes one pixel per valid/ready handshake into a one-entry prefetch
// buffer, raises a sticky underrun flag and pulses done after the latch period.
// Optional build macro WS2812B_BRIGHTNESS_EN adds a brightness port; each channel
// is then scaled when the pixel is accepted.
module ws2812b_chain #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_PIXELS  = 8,
  parameter int T0H_NS      = 400,
  parameter int T0L_NS      = 850,
  parameter int T1H_NS      = 800,
  parameter int T1L_NS      = 450,
  parameter int TRES_US     = 50
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  output logic       bit_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  // Nanoseconds to clock cycles, rounded to nearest.
  function automatic int ns2cyc(input int khz, input int ns);
    longint p;
    p = longint'(khz) * longint'(ns) + 64'sd500_000;
    return int'(p / 64'sd1_000_000);
  endfunction

  localparam int KHZ     = CLK_FREQ_HZ / 1000;
  localparam int T0H_CYC = ns2cyc(KHZ, T0H_NS);
  localparam int T0L_CYC = ns2cyc(KHZ, T0L_NS);
  localparam int T1H_CYC = ns2cyc(KHZ, T1H_NS);
  localparam int T1L_CYC = ns2cyc(KHZ, T1L_NS);
  localparam int RES_CYC = int'(longint'(KHZ) * longint'(TRES_US) / 64'sd1000);

  localparam int MAX_A   = (T0H_CYC > T0L_CYC) ? T0H_CYC : T0L_CYC;
  localparam int MAX_B   = (T1H_CYC > T1L_CYC) ? T1H_CYC : T1L_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > RES_CYC) ? MAX_C : RES_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PX_W    = $clog2(NUM_PIXELS + 1);

  // Every phase must last at least one cycle and the frame size must be sane.
  if (T0H_CYC < 1 || T0L_CYC < 1 || T1H_CYC < 1 || T1L_CYC < 1 || RES_CYC < 1) begin : g_bad_timing
    $error("ws2812b_chain: a derived cycle count is below 1");
  end
  if (NUM_PIXELS < 1 || NUM_PIXELS > 1024) begin : g_bad_pixels
    $error("ws2812b_chain: NUM_PIXELS out of range 1..1024");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        bit_idx;
  logic [23:0]       shreg;
  logic [23:0]       buf_data;
  logic              buf_full;
  logic [PX_W-1:0]   px_fetched;
  logic [PX_W-1:0]   px_sent;
  logic [23:0]       pix_in;
  logic              handshake;

  logic              cnt_clr;
  logic              load_sr;
  logic              shift_sr;
  logic              set_ur;
  logic              frame_start;
  logic              done_nx;
  logic [CNT_W-1:0]  hi_end;
  logic [CNT_W-1:0]  lo_end;

`ifdef WS2812B_BRIGHTNESS_EN
  // Channel scaling: c * (brightness + 1) / 256 with a 16-bit product.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, br} + 16'd1);
    return p[15:8];
  endfunction

  assign pix_in = {scale(g, brightness), scale(r, brightness), scale(b, brightness)};
`else
  assign pix_in = {g, r, b};
`endif

  assign busy        = (state != S_IDLE);
  assign pixel_ready = busy && !buf_full && (px_fetched < PX_W'(NUM_PIXELS));
  assign handshake   = pixel_valid && pixel_ready;
  assign hi_end      = shreg[23] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign lo_end      = shreg[23] ? CNT_W'(T1L_CYC - 1) : CNT_W'(T0L_CYC - 1);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and one-cycle control strobes.
  always_comb begin
    state_nx    = state;
    cnt_clr     = 1'b0;
    load_sr     = 1'b0;
    shift_sr    = 1'b0;
    set_ur      = 1'b0;
    frame_start = 1'b0;
    done_nx     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done) begin
          frame_start = 1'b1;
          state_nx    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (buf_full) begin
          load_sr  = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt == hi_end) begin
          cnt_clr  = 1'b1;
          state_nx = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt == lo_end) begin
          cnt_clr = 1'b1;
          if (bit_idx != 5'd0) begin
            shift_sr = 1'b1;
            state_nx = S_HIGH;
          end else if (px_sent == PX_W'(NUM_PIXELS)) begin
            state_nx = S_LATCH;
          end else if (buf_full) begin
            load_sr  = 1'b1;
            state_nx = S_HIGH;
          end else begin
            // Source fell behind: hold the line low until a pixel arrives.
            set_ur   = 1'b1;
            state_nx = S_WAIT;
          end
        end
      end
      S_LATCH: begin
        if (cnt == CNT_W'(RES_CYC - 1)) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control registers: timing counter, bit index, buffer flag, pixel counters, flags, line.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt        <= '0;
      bit_idx    <= 5'd0;
      buf_full   <= 1'b0;
      px_fetched <= '0;
      px_sent    <= '0;
      underrun   <= 1'b0;
      done       <= 1'b0;
      bit_out    <= 1'b0;
    end else begin
      if (cnt_clr || state == S_IDLE || state == S_WAIT) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;

      if (load_sr)       bit_idx <= 5'd23;
      else if (shift_sr) bit_idx <= bit_idx - 5'd1;

      if (handshake)    buf_full <= 1'b1;
      else if (load_sr) buf_full <= 1'b0;

      if (frame_start)    px_fetched <= '0;
      else if (handshake) px_fetched <= px_fetched + 1'b1;

      if (frame_start)  px_sent <= '0;
      else if (load_sr) px_sent <= px_sent + 1'b1;

      if (frame_start) underrun <= 1'b0;
      else if (set_ur) underrun <= 1'b1;

      done    <= done_nx;
      bit_out <= (state == S_HIGH);
    end
  end

  // Pixel data path: buffer capture and MSB-first shift register.
  always_ff @(posedge clock) begin
    if (handshake) buf_data <= pix_in;
    if (load_sr)       shreg <= buf_data;
    else if (shift_sr) shreg <= {shreg[22:0], 1'b0};
  end

endmodule
